// File: rtl/vga_pkg.sv
// Shared VESA 800x600@60 timing constants and helpers for every block that
// interprets hcount/vcount (timing generator, pixel sources, frame writers).
package vga_pkg;

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned FRAME_W = 16;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [FRAME_W-1:0] frame_t;

    // Horizontal timing in pixel clocks; sync stop is the last high column.
    localparam cnt_t H_TOTAL      = 11'd1056;
    localparam cnt_t H_VISIBLE    = 11'd800;
    localparam cnt_t H_SYNC_START = 11'd840;
    localparam cnt_t H_SYNC_STOP  = 11'd967;
    localparam cnt_t H_LAST       = H_TOTAL - 11'd1;

    // Vertical timing in lines; sync stop is the last high line.
    localparam cnt_t V_TOTAL      = 11'd628;
    localparam cnt_t V_VISIBLE    = 11'd600;
    localparam cnt_t V_SYNC_START = 11'd601;
    localparam cnt_t V_SYNC_STOP  = 11'd604;
    localparam cnt_t V_LAST       = V_TOTAL - 11'd1;

    // WAIT_FIRST presents the origin on the first enabled edge after reset.
    typedef enum logic {
        ST_WAIT_FIRST = 1'b0,
        ST_RUN        = 1'b1
    } vga_state_t;

    function automatic logic in_range(input cnt_t value, input cnt_t lo, input cnt_t hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VESA 800x600@60 raster timing: pixel/line counters with sync, blanking,
// start-of-frame and completed-frame count, all registered and aligned.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               hblnk,
    output logic               vblnk,
    output logic               sof,
    output logic [FRAME_W-1:0] frame_cnt
);

    vga_state_t state_q, state_d;
    cnt_t       hcount_q, hcount_d;
    cnt_t       vcount_q, vcount_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       hblnk_q, hblnk_d;
    logic       vblnk_q, vblnk_d;
    logic       sof_q, sof_d;
    frame_t     frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT_FIRST;
            hcount_q    <= '0;
            vcount_q    <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            hblnk_q     <= 1'b0;
            vblnk_q     <= 1'b0;
            sof_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            hblnk_q     <= hblnk_d;
            vblnk_q     <= vblnk_d;
            sof_q       <= sof_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next counts first, then flags decoded from those counts so they land together.
    always_comb begin
        state_d     = state_q;
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        hblnk_d     = hblnk_q;
        vblnk_d     = vblnk_q;
        sof_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (en) begin
            case (state_q)
                ST_WAIT_FIRST: begin
                    hcount_d = '0;
                    vcount_d = '0;
                    state_d  = ST_RUN;
                end
                ST_RUN: begin
                    if (hcount_q == H_LAST) begin
                        hcount_d = '0;
                        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
                    end else begin
                        hcount_d = hcount_q + CNT_W'(1);
                    end
                end
                default: begin
                    hcount_d = '0;
                    vcount_d = '0;
                    state_d  = ST_WAIT_FIRST;
                end
            endcase

            sof_d   = (hcount_d == '0) && (vcount_d == '0);
            hblnk_d = (hcount_d >= H_VISIBLE);
            vblnk_d = (vcount_d >= V_VISIBLE);
            hsync_d = in_range(hcount_d, H_SYNC_START, H_SYNC_STOP);
            vsync_d = in_range(vcount_d, V_SYNC_START, V_SYNC_STOP);

            // The origin shown straight after reset is not a completed frame.
            if (sof_d && (state_q == ST_RUN)) begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
        end
    end

    assign hcount    = hcount_q;
    assign vcount    = vcount_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign hblnk     = hblnk_q;
    assign vblnk     = vblnk_q;
    assign sof       = sof_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a behavioural raster model queues the
// expected outputs for each edge and they are compared once the DUT updates.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        sof;
        logic [15:0] fc;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        sof;
    logic [15:0] frame_cnt;

    int n_pass  = 0;
    int n_total = 0;

    obs_t exp_q[$];

    int          m_h;
    int          m_v;
    bit          m_run;
    logic [15:0] m_fc;
    obs_t        m_last;

    vga_timing_gen dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .hcount    (hcount),
        .vcount    (vcount),
        .hsync     (hsync),
        .vsync     (vsync),
        .hblnk     (hblnk),
        .vblnk     (vblnk),
        .sof       (sof),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o = '{hcount, vcount, hsync, vsync, hblnk, vblnk, sof, frame_cnt};
        return o;
    endfunction

    task automatic model_reset();
        m_h    = 0;
        m_v    = 0;
        m_run  = 1'b0;
        m_fc   = 16'd0;
        m_last = '0;
        exp_q.delete();
    endtask

    // Behavioural reference for one clock edge with the given enable.
    task automatic model_step(input logic e, output obs_t x);
        if (!e) begin
            x     = m_last;
            x.sof = 1'b0;
        end else begin
            if (!m_run) begin
                m_h   = 0;
                m_v   = 0;
                m_run = 1'b1;
                x.sof = 1'b1;
            end else begin
                if (m_h == 1055) begin
                    m_h = 0;
                    m_v = (m_v == 627) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
                x.sof = (m_h == 0) && (m_v == 0);
                if (x.sof) m_fc = m_fc + 16'd1;
            end
            x.h  = 11'(m_h);
            x.v  = 11'(m_v);
            x.hb = (m_h >= 800);
            x.vb = (m_v >= 600);
            x.hs = (m_h >= 840) && (m_h <= 967);
            x.vs = (m_v >= 601) && (m_v <= 604);
            x.fc = m_fc;
        end
        m_last = x;
    endtask

    // Drive one edge: queue the expectation, then return what the DUT shows.
    task automatic tick(input logic e, output obs_t got);
        obs_t x;
        en = e;
        model_step(e, x);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        got = observe();
    endtask

    // Jump the raster position (and frame count) to shorten long scenarios.
    task automatic preload(input int h, input int v, input logic [15:0] fc);
        force dut.hcount_q    = 11'(h);
        force dut.vcount_q    = 11'(v);
        force dut.frame_cnt_q = fc;
        #1;
        release dut.hcount_q;
        release dut.vcount_q;
        release dut.frame_cnt_q;
        m_h       = h;
        m_v       = v;
        m_fc      = fc;
        m_last.h  = 11'(h);
        m_last.v  = 11'(v);
        m_last.fc = fc;
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b1;
        en  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        got = observe();
        n_total++;
        if (got !== obs_t'(0)) $display("FAIL reset_state got=%h exp=%h", got, obs_t'(0));
        else n_pass++;
    endtask

    task automatic test_first_cycle();
        obs_t got, x;
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, got);
        x = exp_q.pop_front();
        n_total++;
        if (got !== x) $display("FAIL first_cycle got=%h exp=%h", got, x);
        else n_pass++;
        n_total++;
        if (got.sof !== 1'b1 || got.fc !== 16'd0 || got.h !== 11'd0 || got.v !== 11'd0)
            $display("FAIL first_sof sof=%b fc=%0d h=%0d v=%0d exp sof=1 fc=0 h=0 v=0",
                     got.sof, got.fc, got.h, got.v);
        else n_pass++;
    endtask

    task automatic test_line();
        obs_t got, x;
        int   hs_cnt  = 0;
        int   hb_rise = -1;
        logic prev_hb = 1'b0;
        int   bad     = 0;
        for (int i = 0; i < 1056; i++) begin
            tick(1'b1, got);
            x = exp_q.pop_front();
            if (got.hs) hs_cnt++;
            if (got.hb && !prev_hb && hb_rise < 0) hb_rise = int'(got.h);
            prev_hb = got.hb;
            if (got !== x) begin
                bad++;
                if (bad <= 8) $display("FAIL line_scb i=%0d got=%h exp=%h", i, got, x);
            end
        end
        n_total++;
        if (bad != 0) $display("FAIL line_scb_total mismatches=%0d exp=0", bad);
        else n_pass++;
        n_total++;
        if (hs_cnt != 128) $display("FAIL hsync_width got=%0d exp=128", hs_cnt);
        else n_pass++;
        n_total++;
        if (hb_rise != 800) $display("FAIL hblnk_rise got=%0d exp=800", hb_rise);
        else n_pass++;
        n_total++;
        if (got.h !== 11'd0 || got.v !== 11'd1)
            $display("FAIL line_wrap got h=%0d v=%0d exp h=0 v=1", got.h, got.v);
        else n_pass++;
    endtask

    task automatic test_en_hold();
        obs_t got, x;
        int   bad = 0;
        for (int i = 0; i < 839; i++) begin
            tick(1'b1, got);
            x = exp_q.pop_front();
            if (got !== x) bad++;
        end
        n_total++;
        if (bad != 0 || got.h !== 11'd839) $display("FAIL reach_839 mismatches=%0d h=%0d exp h=839", bad, got.h);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1'b0, got);
            x = exp_q.pop_front();
            if (got !== x) begin
                bad++;
                if (bad <= 4) $display("FAIL hold_scb i=%0d got=%h exp=%h", i, got, x);
            end
        end
        n_total++;
        if (bad != 0) $display("FAIL hold_frozen mismatches=%0d exp=0", bad);
        else n_pass++;
        tick(1'b1, got);
        x = exp_q.pop_front();
        n_total++;
        if (got !== x || got.hs !== 1'b1 || got.h !== 11'd840)
            $display("FAIL resume_hsync got=%h exp=%h (h=840 hsync=1)", got, x);
        else n_pass++;
    endtask

    task automatic test_vsync();
        obs_t got, x;
        int   vs_cnt   = 0;
        int   vs_first = -1;
        int   bad      = 0;
        int   guard    = 0;
        preload(1040, 599, m_fc);
        while (m_v != 606 && guard < 10000) begin
            tick(1'b1, got);
            x = exp_q.pop_front();
            guard++;
            if (got.vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = int'(got.v);
            end
            if (got !== x) begin
                bad++;
                if (bad <= 8) $display("FAIL vsync_scb got=%h exp=%h", got, x);
            end
        end
        n_total++;
        if (guard >= 10000) $display("FAIL vsync_timeout cycles=%0d exp<10000", guard);
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL vsync_scb_total mismatches=%0d exp=0", bad);
        else n_pass++;
        n_total++;
        if (vs_cnt != 4224) $display("FAIL vsync_width got=%0d exp=4224", vs_cnt);
        else n_pass++;
        n_total++;
        if (vs_first != 601) $display("FAIL vsync_start_line got=%0d exp=601", vs_first);
        else n_pass++;
    endtask

    task automatic test_frame_wrap();
        obs_t got, x;
        int   sofs = 0;
        int   bad  = 0;
        preload(1050, 627, 16'hFFFF);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, got);
            x = exp_q.pop_front();
            if (got.sof) begin
                sofs++;
                n_total++;
                if (got.fc !== 16'd0 || got.h !== 11'd0 || got.v !== 11'd0)
                    $display("FAIL fc_wrap fc=%0d h=%0d v=%0d exp fc=0 h=0 v=0", got.fc, got.h, got.v);
                else n_pass++;
            end
            if (got !== x) begin
                bad++;
                if (bad <= 4) $display("FAIL wrap_scb i=%0d got=%h exp=%h", i, got, x);
            end
        end
        n_total++;
        if (bad != 0) $display("FAIL wrap_scb_total mismatches=%0d exp=0", bad);
        else n_pass++;
        n_total++;
        if (sofs != 1) $display("FAIL sof_count got=%0d exp=1", sofs);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        obs_t got, x;
        int   bad = 0;
        preload(895, 602, m_fc);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, got);
            x = exp_q.pop_front();
            if (got !== x) bad++;
        end
        n_total++;
        if (bad != 0 || got.h !== 11'd900 || got.v !== 11'd602 || got.hs !== 1'b1 || got.vs !== 1'b1)
            $display("FAIL pre_reset_pos mismatches=%0d h=%0d v=%0d hs=%b vs=%b exp h=900 v=602 hs=1 vs=1",
                     bad, got.h, got.v, got.hs, got.vs);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        got = observe();
        n_total++;
        if (got !== obs_t'(0)) $display("FAIL async_reset got=%h exp=%h", got, obs_t'(0));
        else n_pass++;
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, got);
        x = exp_q.pop_front();
        n_total++;
        if (got !== x || got.sof !== 1'b1 || got.fc !== 16'd0 || got.hs !== 1'b0 || got.hb !== 1'b0)
            $display("FAIL post_reset_first got=%h exp=%h", got, x);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_cycle();
        test_line();
        test_en_hold();
        test_vsync();
        test_frame_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have a clk input, 1 bit: pixel clock, 40 MHz, rising-edge.
REQ-002 The block SHALL have an rst input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have an en input, 1 bit: pixel-advance enable; when low, all state holds.
REQ-004 The block SHALL have an hcount output, 11 bits: current pixel column, 0..1055.
REQ-005 The block SHALL have a vcount output, 11 bits: current line, 0..627.
REQ-006 The block SHALL have an hsync output, 1 bit: horizontal sync, positive polarity.
REQ-007 The block SHALL have a vsync output, 1 bit: vertical sync, positive polarity.
REQ-008 The block SHALL have an hblnk output, 1 bit: horizontal blanking.
REQ-009 The block SHALL have a vblnk output, 1 bit: vertical blanking.
REQ-010 The block SHALL have an sof output, 1 bit: one-cycle start-of-frame pulse.
REQ-011 The block SHALL have a frame_cnt output, 16 bits: completed-frame counter.

Function
REQ-012 Timing SHALL be VESA 800x600@60.
- H: total 1056, visible 800, front porch 40, sync 128, back porch 88.
- V: total 628, visible 600, front porch 1, sync 4, back porch 23.
REQ-013 When en=1, hcount SHALL increment by 1 each clk; at 1055 it SHALL wrap to 0.
REQ-014 vcount SHALL increment only on cycles where hcount wraps 1055->0; at 627 it SHALL wrap to 0 on that same cycle.
REQ-015 hblnk SHALL equal 1 iff hcount >= 800.
REQ-016 vblnk SHALL equal 1 iff vcount >= 600.
REQ-017 hsync SHALL equal 1 iff 840 <= hcount <= 967.
REQ-018 vsync SHALL equal 1 iff 601 <= vcount <= 604, for the full duration of those lines.
REQ-019 All outputs SHALL be registered and mutually aligned: the sync/blank flags describe the hcount/vcount value presented in the same cycle.
- Decode uses next-count values, so there is no extra latency.
REQ-020 sof SHALL be 1 for exactly one en-qualified cycle, when hcount=0 and vcount=0 are presented; otherwise 0.
REQ-021 frame_cnt SHALL increment by 1 in the cycle sof asserts, except the first sof after reset.
- It wraps 65535->0 silently.
REQ-022 With en=0, all outputs SHALL hold their values, and sof SHALL be forced to 0 (no repeated pulse).
REQ-023 Counters SHALL never hold values outside their ranges; out-of-range values SHALL be unreachable by construction.
- No parameter overrides exist.

Reset
REQ-024 On rst=1, the following SHALL be cleared asynchronously: hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, sof=0, frame_cnt=0.
REQ-025 After rst is released, the first en-qualified edge SHALL present hcount=0, vcount=0 with sof=1.
- That sof is the "first sof"; frame_cnt stays 0.
- The counters then advance on subsequent en edges.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with no completion of sync pulses.

Structure
REQ-027 A shared package vga_pkg SHALL hold all timing constants: H/V total, visible, sync start, sync stop.
- Other blocks that read hcount/vcount share them.
REQ-028 The block SHALL be a single module with no sub-modules.
- Counter and decode logic are too small to justify a split.

Verification
REQ-029 Reset release, en=1 -> first cycle hcount=0, vcount=0, sof=1, frame_cnt=0, hsync=0, hblnk=0.
REQ-030 Run one line -> hblnk rises at hcount=800.
- hsync is high for exactly 128 cycles (840..967).
- hcount 1055 is followed by 0 with vcount 0->1.
REQ-031 Run two full frames -> vsync is high for exactly 4*1056=4224 cycles per frame, starting at line 601.
- sof period is 663168 cycles; frame_cnt reads 1 after the second sof.
REQ-032 Toggle en low for 50 cycles at hcount=839 -> outputs are frozen and sof stays 0.
- hsync rises on the first en=1 edge after resume (hcount=840).
REQ-033 Assert rst at vcount=602, hcount=900 -> vsync and hsync drop to 0 without a clock edge, and counters read 0.
- After release, behaviour matches REQ-029.
REQ-034 Preload frame_cnt near wrap (force 65535) -> the next non-first sof yields frame_cnt=0.
- Connect to tiff_writer: the image is 1056x628 with an 800x600 active region.
